// File: rtl/rho_pi_slice_stage.sv
// Rho/pi permutation stage: buffers one 64-slice state, then streams the
// rho-rotated, pi-repositioned state out slice by slice.
module rho_pi_slice_stage (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [24:0] in_slice,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [24:0] out_slice,
    output logic [5:0]  out_z,
    output logic        out_last
);

    localparam int unsigned N      = 25;
    localparam int unsigned SLICES = 64;
    localparam int unsigned ZW     = 6;

    // Rho offsets indexed by lane 5*y + x.
    localparam logic [ZW-1:0] RHO [N] = '{
        6'd0,  6'd1,  6'd62, 6'd28, 6'd27,
        6'd36, 6'd44, 6'd6,  6'd55, 6'd20,
        6'd3,  6'd10, 6'd43, 6'd25, 6'd39,
        6'd41, 6'd45, 6'd15, 6'd21, 6'd8,
        6'd18, 6'd2,  6'd61, 6'd56, 6'd14
    };

    // (x' + 3y') mod 5 for x' + 3y' in 0..16.
    localparam int unsigned MOD5 [17] = '{
        0, 1, 2, 3, 4, 0, 1, 2, 3, 4, 0, 1, 2, 3, 4, 0, 1
    };

    typedef enum logic {
        LOAD  = 1'b0,
        DRAIN = 1'b1
    } state_t;

    state_t          state_q, state_d;
    logic [ZW-1:0]   wr_cnt_q, wr_cnt_d;
    logic [ZW-1:0]   rd_cnt_q, rd_cnt_d;
    logic            wr_en;
    logic [N-1:0]    slice_buf [SLICES];
    logic [N-1:0]    perm;

    // State and counter registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= LOAD;
            wr_cnt_q <= '0;
            rd_cnt_q <= '0;
        end else begin
            state_q  <= state_d;
            wr_cnt_q <= wr_cnt_d;
            rd_cnt_q <= rd_cnt_d;
        end
    end

    // Slice buffer; only written while loading.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < int'(SLICES); i++) begin
                slice_buf[i] <= '0;
            end
        end else if (wr_en) begin
            slice_buf[wr_cnt_q] <= in_slice;
        end
    end

    // Next-state logic: load all slices, then drain all slices.
    always_comb begin
        state_d  = state_q;
        wr_cnt_d = wr_cnt_q;
        rd_cnt_d = rd_cnt_q;
        wr_en    = 1'b0;
        case (state_q)
            LOAD: begin
                if (in_valid) begin
                    wr_en = 1'b1;
                    if (wr_cnt_q == ZW'(SLICES - 1)) begin
                        wr_cnt_d = '0;
                        state_d  = DRAIN;
                    end else begin
                        wr_cnt_d = wr_cnt_q + ZW'(1);
                    end
                end
            end
            DRAIN: begin
                if (out_ready) begin
                    if (rd_cnt_q == ZW'(SLICES - 1)) begin
                        rd_cnt_d = '0;
                        state_d  = LOAD;
                    end else begin
                        rd_cnt_d = rd_cnt_q + ZW'(1);
                    end
                end
            end
            default: state_d = LOAD;
        endcase
    end

    // Output lane (x',y') takes source lane (x'+3y' mod 5, x') from slice z - r.
    for (genvar yo = 0; yo < 5; yo++) begin : g_row
        for (genvar xo = 0; xo < 5; xo++) begin : g_lane
            localparam int unsigned SRC = 5 * xo + MOD5[xo + 3 * yo];
            logic [ZW-1:0] src_z;
            assign src_z              = rd_cnt_q - RHO[SRC];
            assign perm[5 * yo + xo]  = slice_buf[src_z][SRC];
        end
    end

    // Handshake and data outputs depend on registers only.
    assign in_ready  = (state_q == LOAD);
    assign out_valid = (state_q == DRAIN);
    assign out_z     = rd_cnt_q;
    assign out_last  = (state_q == DRAIN) && (rd_cnt_q == ZW'(SLICES - 1));
    assign out_slice = (state_q == DRAIN) ? perm : '0;

endmodule

// File: tb/tb_rho_pi_slice_stage.sv
// Scoreboard bench for rho_pi_slice_stage: a forward rho/pi model feeds an
// expected-slice queue that a negedge monitor drains on each output transfer.
module tb_rho_pi_slice_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [24:0] in_slice;
    logic        out_valid;
    logic        out_ready;
    logic [24:0] out_slice;
    logic [5:0]  out_z;
    logic        out_last;

    rho_pi_slice_stage dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_slice  (in_slice),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_slice (out_slice),
        .out_z     (out_z),
        .out_last  (out_last)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [24:0] s;
        logic [5:0]  z;
        logic        last;
    } exp_t;

    int          tests = 0;
    int          fails = 0;
    exp_t        sb[$];
    logic [24:0] blk     [64];
    logic [24:0] exp_blk [64];
    bit          rand_ready     = 1'b0;
    bit          hold_ready     = 1'b0;
    bit          chk_after_last = 1'b0;

    // Rho offsets as rows of y, columns of x.
    int rho_y [5][5] = '{
        '{0, 1, 62, 28, 27},
        '{36, 44, 6, 55, 20},
        '{3, 10, 43, 25, 39},
        '{41, 45, 15, 21, 8},
        '{18, 2, 61, 56, 14}
    };

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Forward model: bit (x,y) at slice z moves to lane (y, 2x+3y mod 5) at slice z+r.
    function automatic void model_push();
        int zd;
        int ld;
        for (int z = 0; z < 64; z++) exp_blk[z] = '0;
        for (int z = 0; z < 64; z++) begin
            for (int y = 0; y < 5; y++) begin
                for (int x = 0; x < 5; x++) begin
                    if (blk[z][5 * y + x]) begin
                        zd = (z + rho_y[y][x]) % 64;
                        ld = 5 * ((2 * x + 3 * y) % 5) + y;
                        exp_blk[zd][ld] = 1'b1;
                    end
                end
            end
        end
        for (int z = 0; z < 64; z++) begin
            sb.push_back('{exp_blk[z], 6'(z), (z == 63)});
        end
    endfunction

    // Ready generator: always ready, random, or forced low.
    initial begin
        out_ready = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            if (hold_ready)      out_ready = 1'b0;
            else if (rand_ready) out_ready = ($urandom_range(0, 3) != 0);
            else                 out_ready = 1'b1;
        end
    end

    // Monitor: compare each output transfer against the queue head.
    always @(negedge clk) begin
        exp_t e;
        if (!rst) begin
            if (chk_after_last) begin
                check("reload_in_ready", 32'(in_ready), 32'd1);
                check("idle_after_last", 32'(out_valid), 32'd0);
                chk_after_last = 1'b0;
            end
            if (out_valid) check("in_ready_in_drain", 32'(in_ready), 32'd0);
            if (out_valid && out_ready) begin
                if (sb.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL unexpected_output: z=%0d slice=%h none expected", out_z, out_slice);
                end else begin
                    e = sb.pop_front();
                    check("out_slice", 32'(out_slice), 32'(e.s));
                    check("out_z", 32'(out_z), 32'(e.z));
                    check("out_last", 32'(out_last), 32'(e.last));
                    if (e.last) chk_after_last = 1'b1;
                end
            end
        end
    end

    task automatic clear_blk();
        for (int z = 0; z < 64; z++) blk[z] = '0;
    endtask

    task automatic rand_blk();
        for (int z = 0; z < 64; z++) blk[z] = 25'($urandom);
    endtask

    task automatic load_block(input bit gaps);
        int n = 0;
        while (!in_ready && n < 500) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (!in_ready) begin
            tests++;
            fails++;
            $display("FAIL load_wait_timeout: in_ready=%b expected 1", in_ready);
        end
        model_push();
        for (int z = 0; z < 64; z++) begin
            if (gaps) begin
                repeat ($urandom_range(0, 2)) begin
                    in_valid = 1'b0;
                    in_slice = 25'($urandom);
                    @(posedge clk);
                    #1;
                end
            end
            in_valid = 1'b1;
            in_slice = blk[z];
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
    endtask

    task automatic wait_drain(input bit pulses);
        int n = 0;
        forever begin
            @(posedge clk);
            #1;
            n++;
            if (sb.size() == 0 && in_ready) break;
            if (n > 3000) begin
                tests++;
                fails++;
                $display("FAIL drain_timeout: %0d outputs still pending, expected 0", sb.size());
                sb.delete();
                break;
            end
            if (pulses) begin
                in_valid = 1'($urandom_range(0, 1));
                in_slice = 25'($urandom);
            end
        end
        in_valid = 1'b0;
    endtask

    initial begin
        int n;
        rst      = 1'b1;
        in_valid = 1'b0;
        in_slice = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_z", 32'(out_z), 32'd0);
        check("rst_out_last", 32'(out_last), 32'd0);
        check("rst_out_slice", 32'(out_slice), 32'd0);
        @(negedge clk);
        rst = 1'b0;

        // Single-bit directed blocks: identity lane, rotate+pi, wrap.
        clear_blk(); blk[0] = 25'h0000001; load_block(1'b0); wait_drain(1'b0);
        clear_blk(); blk[0] = 25'h0000002; load_block(1'b0); wait_drain(1'b0);
        clear_blk(); blk[5] = 25'h0000004; load_block(1'b0); wait_drain(1'b0);

        // Random blocks with input gaps, random backpressure and ignored drain-time writes.
        rand_ready = 1'b1;
        for (int b = 0; b < 3; b++) begin
            rand_blk();
            load_block(1'b1);
            wait_drain(1'b1);
        end
        rand_ready = 1'b0;

        // Stall at out_z = 7 for ten cycles.
        rand_blk();
        load_block(1'b0);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!(out_valid && out_z == 6'd6) && n < 200);
        hold_ready = 1'b1;
        @(posedge clk);
        repeat (10) begin
            @(negedge clk);
            check("bp_out_valid", 32'(out_valid), 32'd1);
            check("bp_out_z", 32'(out_z), 32'd7);
            check("bp_out_slice", 32'(out_slice), 32'(exp_blk[7]));
            check("bp_out_last", 32'(out_last), 32'd0);
            check("bp_in_ready", 32'(in_ready), 32'd0);
        end
        hold_ready = 1'b0;
        wait_drain(1'b0);

        // All-ones block followed immediately by a second block.
        for (int z = 0; z < 64; z++) blk[z] = 25'h1FFFFFF;
        load_block(1'b0);
        wait_drain(1'b0);
        rand_blk();
        load_block(1'b0);
        wait_drain(1'b0);

        // Asynchronous reset at out_z = 30, then a fresh block.
        rand_blk();
        load_block(1'b0);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!(out_valid && out_z == 6'd30) && n < 200);
        #2;
        rst = 1'b1;
        sb.delete();
        chk_after_last = 1'b0;
        #1;
        check("async_rst_out_valid", 32'(out_valid), 32'd0);
        check("async_rst_in_ready", 32'(in_ready), 32'd1);
        check("async_rst_out_z", 32'(out_z), 32'd0);
        check("async_rst_out_slice", 32'(out_slice), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        rand_blk();
        load_block(1'b0);
        wait_drain(1'b0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
